tl_frag_sequencer: RTL and testbench
====================================

TL_FRAG_SEQUENCER -- requirements
Module: tl_frag_sequencer

Interface
REQ-001 Param BEAT_BYTES, default 8, fragment width in bytes; fixed 8 (mask 8 bits, data 64 bits).
REQ-002 Param MAX_LG_SIZE, default 6, largest legal request lg2 size (64 B).
REQ-003 clock  in  1  clock; all state on posedge clock.
REQ-004 reset  in  1  reset, synchronous, active-high.
REQ-005 in_valid/in_ready  in/out  1/1  upstream A-channel handshake (fed by a Repeater).
REQ-006 in_opcode, in_param, in_size  in  3 each  TileLink A fields.
REQ-007 in_source  in  6; in_address  in  32; in_mask  in  8; in_data  in  64.
REQ-008 repeat  out  1  to upstream Repeater io_repeat; hold current request after this handshake.
REQ-009 out_valid/out_ready  out/in  1/1  downstream fragment handshake.
REQ-010 out_opcode, out_param, out_size (3 each), out_source (6), out_address (32), out_mask (8), out_data (64)  out  fragment fields.
REQ-011 out_frag_idx  out  3  fragment index in request; out_frag_last  out  1  final fragment.
REQ-012 err  out  1  sticky: illegal size (> MAX_LG_SIZE) seen.

Function
REQ-013 Beats N = 1 if in_size <= 3, else 2^(in_size-3) (max 8); fragment out_size = min(in_size, 3).
REQ-014 3-bit counter cnt; state IDLE when cnt==0, BURST otherwise.
REQ-015 Fragment address = (in_address with bits [in_size-1:0] cleared) + cnt*8 when N>1; in_address unchanged when N==1.
REQ-016 Get (opcode 4), N>1: one request yields N fragments; out_mask forced 8'hFF; repeat=1 on every in handshake except last.
REQ-017 PutFull/PutPartial (0/1), N>1: each input beat yields one fragment, in_mask/in_data passed; repeat=0.
REQ-018 Other opcodes: same as Put rule (one fragment per input beat).
REQ-019 cnt increments on each in handshake; wraps to 0 on last (cnt==N-1); last sets out_frag_last.
REQ-020 One-entry output register slice: latency 1 cycle in->out; full throughput (in_ready = ~out_valid | out_ready).
REQ-021 Output fields stable while out_valid & ~out_ready.
REQ-022 repeat valid only when in_valid; combinational from cnt and in fields; 0 otherwise.
REQ-023 Illegal size 7: forwarded as single unfragmented beat, out_frag_last=1, err set; cnt untouched.
REQ-024 Simultaneous out handshake and new in handshake: register reloaded same cycle, no bubble.

Reset
REQ-025 Reset: cnt=0, out_valid=0, err=0; out_frag_idx=0, out_frag_last=0; data fields don't-care.
REQ-026 Reset mid-burst discards remaining fragments; upstream Repeater reset concurrently.
REQ-027 in_ready=1 during reset deasserted? No: in_ready=0 while reset asserted.

Configuration
REQ-028 Macro TL_FRAG_PERF_EN: when defined, adds output perf_frags (16 bits), counts out handshakes, saturates at 16'hFFFF, reset to 0.
REQ-029 Without TL_FRAG_PERF_EN: port and counter absent; all other behaviour identical.

Structure
REQ-030 Shared package tl_frag_pkg: opcode constants (PUT_FULL=0, PUT_PARTIAL=1, GET=4), BEAT_LG=3, MAX_LG_SIZE, fragment struct typedef (fields of REQ-010/011).
REQ-031 One sub-module tl_frag_slice: one-entry valid/ready register slice of the fragment struct.

Verification
REQ-032 Get size=6 addr 0x1000_0030, out_ready=1 -> 8 fragments addr 0x1000_0000..0x1000_0038 step 8, size 3, mask FF, idx 0..7, last on idx 7, repeat=1 for first 7.
REQ-033 PutFull size=4 addr 0x200, 2 beats data A/B -> 2 fragments addr 0x200/0x208, data A/B, repeat=0, last on 2nd.
REQ-034 Get size=2 addr 0x104 -> single fragment addr 0x104 size 2, mask passed, last=1, repeat=0.
REQ-035 out_ready low 3 cycles mid Get size=5 -> fields held, in_ready=0, no fragment lost or duplicated; 4 total.
REQ-036 Reset asserted after fragment 2 of Get size=6 -> out_valid=0, cnt=0 next cycle; next Get starts idx 0.
REQ-037 Get size=7 -> one fragment, err=1 sticky until reset; with TL_FRAG_PERF_EN perf_frags increments by 1.

Source files
------------

// File: rtl/tl_frag_pkg.sv
// Shared definitions for the TileLink A-channel fragment sequencer:
// opcode constants, beat geometry, sequencer state type and the
// fragment record carried through the output register slice.
package tl_frag_pkg;

  localparam logic [2:0] PUT_FULL    = 3'd0;
  localparam logic [2:0] PUT_PARTIAL = 3'd1;
  localparam logic [2:0] GET         = 3'd4;

  localparam int BEAT_LG     = 3;
  localparam int MAX_LG_SIZE = 6;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } seq_state_t;

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [5:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [2:0]  frag_idx;
    logic        frag_last;
  } frag_t;

  localparam int FRAG_W = $bits(frag_t);

  // Number of 8-byte beats covered by a legal request of lg2 size 'size'.
  function automatic logic [3:0] beats_for(input logic [2:0] size);
    if (size <= 3'(BEAT_LG)) return 4'd1;
    return 4'd1 << (size - 3'(BEAT_LG));
  endfunction

endpackage

// File: rtl/tl_frag_slice.sv
// One-entry valid/ready register slice. Only the valid bit is reset;
// the payload register loads on every accepted transfer and is held
// unchanged while the downstream side stalls.
module tl_frag_slice #(
  parameter int W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data
);

  logic         vld_p1;
  logic [W-1:0] data_p1;

  // The slot can take a new entry when empty or when it drains this cycle.
  assign in_ready  = ~vld_p1 | out_ready;
  assign out_valid = vld_p1;
  assign out_data  = data_p1;

  // Stage p1 occupancy.
  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1 <= 1'b0;
    end else if (in_ready) begin
      vld_p1 <= in_valid;
    end
  end

  // Stage p1 payload, reloaded on accept so a drain and refill share a cycle.
  always_ff @(posedge clock) begin
    if (in_valid && in_ready) begin
      data_p1 <= in_data;
    end
  end

endmodule

// File: rtl/tl_frag_sequencer.sv
// TileLink A-channel fragment sequencer. Splits requests wider than one
// 8-byte beat into beat-sized fragments: a multi-beat Get is replayed by the
// upstream Repeater (held via repeat_hold) once per fragment, while Put and
// other opcodes produce one fragment per incoming data beat. Fragments leave
// through a one-entry register slice.
// 'repeat' is a reserved word, so the Repeater hold output is repeat_hold.
// Optional build macro: TL_FRAG_PERF_EN adds the perf_frags output, a
// saturating count of output handshakes.
module tl_frag_sequencer
  import tl_frag_pkg::*;
#(
  parameter int BEAT_BYTES  = 8,
  parameter int MAX_LG_SIZE = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_opcode,
  input  logic [2:0]  in_param,
  input  logic [2:0]  in_size,
  input  logic [5:0]  in_source,
  input  logic [31:0] in_address,
  input  logic [7:0]  in_mask,
  input  logic [63:0] in_data,
  output logic        repeat_hold,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  out_opcode,
  output logic [2:0]  out_param,
  output logic [2:0]  out_size,
  output logic [5:0]  out_source,
  output logic [31:0] out_address,
  output logic [7:0]  out_mask,
  output logic [63:0] out_data,
  output logic [2:0]  out_frag_idx,
  output logic        out_frag_last,
  output logic        err
`ifdef TL_FRAG_PERF_EN
  ,
  output logic [15:0] perf_frags
`endif
);

  logic [2:0]  cnt_p0;
  logic [2:0]  cnt_nxt;
  seq_state_t  state;
  logic        legal;
  logic        multi;
  logic        last;
  logic        is_get;
  logic        fire;
  logic        slice_ready;
  logic [3:0]  n_beats;
  logic [31:0] size_mask;
  logic [31:0] frag_addr;
  frag_t       frag_in;
  frag_t       frag_out;

  // Request decode and fragment assembly from the beat counter.
  always_comb begin
    legal     = (in_size <= 3'(MAX_LG_SIZE));
    n_beats   = legal ? beats_for(in_size) : 4'd1;
    multi     = (n_beats != 4'd1);
    last      = ~multi | ({1'b0, cnt_p0} == (n_beats - 4'd1));
    is_get    = (in_opcode == GET);
    size_mask = (32'd1 << in_size) - 32'd1;
    frag_addr = in_address;
    if (multi) begin
      frag_addr = (in_address & ~size_mask) + (32'(cnt_p0) * 32'(BEAT_BYTES));
    end

    frag_in           = '0;
    frag_in.opcode    = in_opcode;
    frag_in.param     = in_param;
    frag_in.size      = (legal && (in_size > 3'(BEAT_LG))) ? 3'(BEAT_LG) : in_size;
    frag_in.source    = in_source;
    frag_in.address   = frag_addr;
    frag_in.mask      = (is_get && multi) ? 8'hFF : in_mask;
    frag_in.data      = in_data;
    frag_in.frag_idx  = multi ? cnt_p0 : 3'd0;
    frag_in.frag_last = last;
  end

  assign in_ready    = ~reset & slice_ready;
  assign fire        = in_valid & in_ready;
  assign repeat_hold = in_valid & is_get & multi & ~last;

  // Sequencer next state: idle at cnt 0, bursting otherwise; illegal sizes leave cnt alone.
  always_comb begin
    cnt_nxt = cnt_p0;
    state   = (cnt_p0 == 3'd0) ? IDLE : BURST;
    case (state)
      IDLE: begin
        if (fire && legal && !last) cnt_nxt = 3'd1;
      end
      BURST: begin
        if (fire && legal) cnt_nxt = last ? 3'd0 : cnt_p0 + 3'd1;
      end
      default: cnt_nxt = 3'd0;
    endcase
  end

  // Stage p0 beat counter register.
  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_p0 <= 3'd0;
    end else begin
      cnt_p0 <= cnt_nxt;
    end
  end

  // Sticky flag for accepted requests whose size exceeds the legal maximum.
  always_ff @(posedge clock) begin
    if (reset) begin
      err <= 1'b0;
    end else if (fire && !legal) begin
      err <= 1'b1;
    end
  end

  // Stage p0 -> p1 boundary: output register slice.
  tl_frag_slice #(
    .W(FRAG_W)
  ) u_slice (
    .clock     (clock),
    .reset     (reset),
    .in_valid  (fire),
    .in_ready  (slice_ready),
    .in_data   (frag_in),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (frag_out)
  );

  assign out_opcode    = frag_out.opcode;
  assign out_param     = frag_out.param;
  assign out_size      = frag_out.size;
  assign out_source    = frag_out.source;
  assign out_address   = frag_out.address;
  assign out_mask      = frag_out.mask;
  assign out_data      = frag_out.data;
  // Index and last flag read as zero whenever the slot is empty, including after reset.
  assign out_frag_idx  = out_valid ? frag_out.frag_idx : 3'd0;
  assign out_frag_last = out_valid & frag_out.frag_last;

`ifdef TL_FRAG_PERF_EN
  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  // Saturating count of fragments accepted downstream.
  always_ff @(posedge clock) begin
    if (reset) begin
      perf_frags <= 16'd0;
    end else if (out_valid && out_ready) begin
      perf_frags <= sat_inc(perf_frags);
    end
  end
`endif

endmodule

// File: tb/tb_tl_frag_sequencer.sv
// Self-checking bench for tl_frag_sequencer. The bench plays the upstream
// Repeater and the downstream sink; expected fragments are derived from the
// request fields with plain arithmetic and queued in order.
module tb_tl_frag_sequencer;

  localparam logic [2:0] OP_GET = 3'd4;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [2:0]  in_opcode = '0;
  logic [2:0]  in_param = '0;
  logic [2:0]  in_size = '0;
  logic [5:0]  in_source = '0;
  logic [31:0] in_address = '0;
  logic [7:0]  in_mask = '0;
  logic [63:0] in_data = '0;
  logic        repeat_hold;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [2:0]  out_opcode;
  logic [2:0]  out_param;
  logic [2:0]  out_size;
  logic [5:0]  out_source;
  logic [31:0] out_address;
  logic [7:0]  out_mask;
  logic [63:0] out_data;
  logic [2:0]  out_frag_idx;
  logic        out_frag_last;
  logic        err;
`ifdef TL_FRAG_PERF_EN
  logic [15:0] perf_frags;
`endif

  typedef struct packed {
    logic [2:0]  opcode;
    logic [2:0]  param;
    logic [2:0]  size;
    logic [5:0]  source;
    logic [31:0] address;
    logic [7:0]  mask;
    logic [63:0] data;
    logic [2:0]  frag_idx;
    logic        frag_last;
  } exp_t;

  exp_t expq[$];
  int   checks = 0;
  int   errors = 0;
  int   popped = 0;

  tl_frag_sequencer dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_opcode     (in_opcode),
    .in_param      (in_param),
    .in_size       (in_size),
    .in_source     (in_source),
    .in_address    (in_address),
    .in_mask       (in_mask),
    .in_data       (in_data),
    .repeat_hold   (repeat_hold),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_opcode    (out_opcode),
    .out_param     (out_param),
    .out_size      (out_size),
    .out_source    (out_source),
    .out_address   (out_address),
    .out_mask      (out_mask),
    .out_data      (out_data),
    .out_frag_idx  (out_frag_idx),
    .out_frag_last (out_frag_last),
    .err           (err)
`ifdef TL_FRAG_PERF_EN
    ,
    .perf_frags    (perf_frags)
`endif
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Expected fragment for beat i of a request, straight from the fragmentation rules.
  function automatic exp_t make_exp(input logic [2:0] op, input logic [2:0] prm,
                                    input logic [2:0] sz, input logic [5:0] src,
                                    input logic [31:0] adr, input logic [7:0] msk,
                                    input logic [63:0] dat, input int i);
    exp_t e;
    int   n;
    bit   legal;
    legal = (sz <= 3'd6);
    n = (!legal || sz <= 3'd3) ? 1 : (1 << (sz - 3'd3));
    e.opcode    = op;
    e.param     = prm;
    e.size      = !legal ? sz : ((sz < 3'd3) ? sz : 3'd3);
    e.source    = src;
    e.address   = (n > 1) ? (((adr >> sz) << sz) + 32'(i * 8)) : adr;
    e.mask      = (op == OP_GET && n > 1) ? 8'hFF : msk;
    e.data      = dat;
    e.frag_idx  = (n > 1) ? 3'(i) : 3'd0;
    e.frag_last = (i == n - 1);
    return e;
  endfunction

  task automatic check_out();
    exp_t o;
    exp_t e;
    if (out_valid && out_ready) begin
      o = {out_opcode, out_param, out_size, out_source, out_address,
           out_mask, out_data, out_frag_idx, out_frag_last};
      if (expq.size() == 0) begin
        chk("spurious_frag", 128'(out_valid), 128'(0));
      end else begin
        e = expq.pop_front();
        popped++;
        chk("frag", 128'(o), 128'(e));
      end
    end
  endtask

  task automatic send_beat(input logic [2:0] op, input logic [2:0] prm, input logic [2:0] sz,
                           input logic [5:0] src, input logic [31:0] adr, input logic [7:0] msk,
                           input logic [63:0] dat, input logic exp_rep, input logic rnd_ready);
    bit hs = 1'b0;
    in_valid   = 1'b1;
    in_opcode  = op;
    in_param   = prm;
    in_size    = sz;
    in_source  = src;
    in_address = adr;
    in_mask    = msk;
    in_data    = dat;
    for (int k = 0; k < 200 && !hs; k++) begin
      if (rnd_ready) out_ready = 1'($urandom_range(0, 1));
      @(negedge clock);
      check_out();
      if (in_ready) begin
        chk("repeat", 128'(repeat_hold), 128'(exp_rep));
        hs = 1'b1;
      end
      tick();
    end
    chk("in_handshake", 128'(hs), 128'(1));
    in_valid = 1'b0;
  endtask

  task automatic do_request(input logic [2:0] op, input logic [2:0] sz,
                            input logic [31:0] adr, input logic rnd_ready);
    int          n;
    logic [2:0]  prm;
    logic [5:0]  src;
    logic [7:0]  msk;
    logic [63:0] dat;
    n   = (sz > 3'd6 || sz <= 3'd3) ? 1 : (1 << (sz - 3'd3));
    prm = 3'($urandom);
    src = 6'($urandom);
    msk = 8'($urandom);
    dat = {$urandom, $urandom};
    for (int i = 0; i < n; i++) begin
      if (op != OP_GET) begin
        msk = 8'($urandom);
        dat = {$urandom, $urandom};
      end
      expq.push_back(make_exp(op, prm, sz, src, adr, msk, dat, i));
      send_beat(op, prm, sz, src, adr, msk, dat, (op == OP_GET) && (i < n - 1), rnd_ready);
    end
  endtask

  task automatic drain();
    for (int k = 0; k < 40 && expq.size() > 0; k++) begin
      out_ready = 1'b1;
      @(negedge clock);
      check_out();
      tick();
    end
    out_ready = 1'b1;
    chk("drained", 128'(expq.size()), 128'(0));
  endtask

  initial begin : main
    logic [2:0]  ops [6];
    logic [2:0]  prm;
    logic [5:0]  src;
    logic [7:0]  msk;
    logic [63:0] dat;
    logic [31:0] adr;
    int          p0;
`ifdef TL_FRAG_PERF_EN
    logic [15:0] perf0;
`endif
    ops[0] = 3'd0; ops[1] = 3'd1; ops[2] = 3'd4;
    ops[3] = 3'd2; ops[4] = 3'd3; ops[5] = 3'd5;

    // Reset state
    reset = 1'b1;
    tick(); tick(); tick();
    @(negedge clock);
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_err", 128'(err), 128'(0));
    chk("rst_idx", 128'(out_frag_idx), 128'(0));
    chk("rst_last", 128'(out_frag_last), 128'(0));
    chk("rst_repeat", 128'(repeat_hold), 128'(0));
    tick();
    reset = 1'b0;
    tick();

    // Get size 6: eight fragments walking the aligned 64-byte block
    do_request(OP_GET, 3'd6, 32'h1000_0030, 1'b0);
    drain();
    // PutFull size 4: two data beats
    do_request(3'd0, 3'd4, 32'h0000_0200, 1'b0);
    drain();
    // Get size 2: single sub-beat fragment
    do_request(OP_GET, 3'd2, 32'h0000_0104, 1'b0);
    drain();

    // Downstream stall in the middle of a Get size 5
    p0  = popped;
    prm = 3'd2; src = 6'd9; msk = 8'h0F; dat = 64'hDEAD_BEEF_0123_4567;
    adr = 32'h0000_0318;
    for (int i = 0; i < 4; i++) expq.push_back(make_exp(OP_GET, prm, 3'd5, src, adr, msk, dat, i));
    send_beat(OP_GET, prm, 3'd5, src, adr, msk, dat, 1'b1, 1'b0);
    send_beat(OP_GET, prm, 3'd5, src, adr, msk, dat, 1'b1, 1'b0);
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clock);
      chk("stall_in_ready", 128'(in_ready), 128'(0));
      chk("stall_out_valid", 128'(out_valid), 128'(1));
      chk("stall_addr", 128'(out_address), 128'(32'h0000_0308));
      chk("stall_idx", 128'(out_frag_idx), 128'(1));
      tick();
    end
    out_ready = 1'b1;
    send_beat(OP_GET, prm, 3'd5, src, adr, msk, dat, 1'b1, 1'b0);
    send_beat(OP_GET, prm, 3'd5, src, adr, msk, dat, 1'b0, 1'b0);
    drain();
    chk("stall_frag_count", 128'(popped - p0), 128'(4));

    // Illegal size 7: forwarded whole, sticky error
`ifdef TL_FRAG_PERF_EN
    perf0 = perf_frags;
`endif
    do_request(OP_GET, 3'd7, 32'h0000_0444, 1'b0);
    drain();
    @(negedge clock);
    chk("err_set", 128'(err), 128'(1));
`ifdef TL_FRAG_PERF_EN
    chk("perf_inc", 128'(perf_frags), 128'(perf0 + 16'd1));
`endif
    tick();
    do_request(3'd1, 3'd3, 32'h0000_0040, 1'b0);
    drain();
    @(negedge clock);
    chk("err_sticky", 128'(err), 128'(1));
    tick();

    // Reset in the middle of a Get size 6
    prm = 3'd1; src = 6'd33; msk = 8'hA5; dat = 64'h1122_3344_5566_7788;
    adr = 32'h0000_0800;
    for (int i = 0; i < 8; i++) expq.push_back(make_exp(OP_GET, prm, 3'd6, src, adr, msk, dat, i));
    for (int i = 0; i < 3; i++) send_beat(OP_GET, prm, 3'd6, src, adr, msk, dat, 1'b1, 1'b0);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_in_ready", 128'(in_ready), 128'(0));
    tick();
    reset = 1'b0;
    expq.delete();
    @(negedge clock);
    chk("midrst_out_valid", 128'(out_valid), 128'(0));
    chk("midrst_idx", 128'(out_frag_idx), 128'(0));
    chk("midrst_last", 128'(out_frag_last), 128'(0));
    chk("midrst_err", 128'(err), 128'(0));
    tick();
    do_request(OP_GET, 3'd4, 32'h0000_0a10, 1'b0);
    drain();

    // Randomized mix with a randomly stalling sink
    for (int r = 0; r < 25; r++) begin
      do_request(ops[$urandom_range(0, 5)], 3'($urandom_range(0, 6)), $urandom, 1'b1);
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
